// File: rtl/sram_word_responder_if.sv
// Requester-side handshake for sram_word_responder: one 32-bit word request,
// acknowledged by o_ack returning high.
interface sram_word_responder_if;
    logic [17:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        i_wren;
    logic        i_rden;
    logic [31:0] o_rdata;
    logic        o_ack;

    modport master (
        output i_addr, i_wdata, i_bmask, i_wren, i_rden,
        input  o_rdata, o_ack
    );

    modport slave (
        input  i_addr, i_wdata, i_bmask, i_wren, i_rden,
        output o_rdata, o_ack
    );
endinterface

// File: rtl/sram_word_responder.sv
// Maps 32-bit word reads/writes onto a 16-bit asynchronous SRAM, low half first.
// Reads take two bus cycles; writes take three, with a WE-high gap while the address moves.
module sram_word_responder (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sram_word_responder_if.slave  bus,
    output logic [2:0]            o_sram_state,
    output logic [17:0]           o_sram_addr,
    inout  wire  [15:0]           io_sram_dq,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_we_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_lb_n,
    output logic                  o_sram_ub_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        WR_LO  = 3'd3,
        WR_GAP = 3'd4,
        WR_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [15:0] word_q, word_nxt;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic [31:0] rdata_q;
    logic [17:0] addr_q, addr_nxt;
    logic        ack;
    logic        dq_oe;
    logic [15:0] dq_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE; write takes priority over read.
    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_wren) begin
                    state_nxt = WR_LO;
                    accept    = 1'b1;
                end else if (bus.i_rden) begin
                    state_nxt = RD_LO;
                    accept    = 1'b1;
                end
            end
            RD_LO:   state_nxt = RD_HI;
            RD_HI:   state_nxt = DONE;
            WR_LO:   state_nxt = WR_GAP;
            WR_GAP:  state_nxt = WR_HI;
            WR_HI:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The SRAM address is registered from the next state so it is stable for the whole cycle.
    always_comb begin
        word_nxt = accept ? bus.i_addr[17:2] : word_q;
        case (state_nxt)
            RD_LO, WR_LO, WR_GAP: addr_nxt = {1'b0, word_nxt, 1'b0};
            RD_HI, WR_HI:         addr_nxt = {1'b0, word_nxt, 1'b1};
            default:              addr_nxt = addr_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q  <= 16'h0;
            wdata_q <= 32'h0;
            bmask_q <= 4'h0;
            addr_q  <= 18'h0;
        end else begin
            addr_q <= addr_nxt;
            if (accept) begin
                word_q  <= bus.i_addr[17:2];
                wdata_q <= bus.i_wdata;
                bmask_q <= bus.i_bmask;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= 32'h0;
        end else if (state == RD_LO) begin
            rdata_q[15:0] <= io_sram_dq;
        end else if (state == RD_HI) begin
            rdata_q[31:16] <= io_sram_dq;
        end
    end

    always_comb begin
        ack         = 1'b0;
        o_sram_ce_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = 16'h0;
        case (state)
            IDLE, DONE: ack = 1'b1;
            RD_LO, RD_HI: begin
                o_sram_ce_n = 1'b0;
                o_sram_oe_n = 1'b0;
                o_sram_lb_n = 1'b0;
                o_sram_ub_n = 1'b0;
            end
            WR_LO: begin
                o_sram_ce_n = 1'b0;
                o_sram_we_n = 1'b0;
                o_sram_lb_n = ~bmask_q[0];
                o_sram_ub_n = ~bmask_q[1];
                dq_oe       = 1'b1;
                dq_out      = wdata_q[15:0];
            end
            // Keep driving the low half through the gap so data holds past WE rising.
            WR_GAP: begin
                o_sram_ce_n = 1'b0;
                dq_oe       = 1'b1;
                dq_out      = wdata_q[15:0];
            end
            WR_HI: begin
                o_sram_ce_n = 1'b0;
                o_sram_we_n = 1'b0;
                o_sram_lb_n = ~bmask_q[2];
                o_sram_ub_n = ~bmask_q[3];
                dq_oe       = 1'b1;
                dq_out      = wdata_q[31:16];
            end
            default: ack = 1'b0;
        endcase
    end

    assign io_sram_dq   = dq_oe ? dq_out : 16'hzzzz;
    assign o_sram_state = state;
    assign o_sram_addr  = addr_q;
    assign bus.o_rdata  = rdata_q;
    assign bus.o_ack    = ack;

endmodule
